// File: rtl/plriscv_pkg.sv
// plriscv_pkg -- shared types for the operand-forwarding select generator.
//   REG_AW_DEF : default register-address width
//   fwd_sel_e  : EX operand mux select encoding
//   fwd_rec_t  : in-flight writer record (rd, reg_write, is_load) at default width
package plriscv_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_WBD   = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } fwd_rec_t;

endpackage

// File: rtl/fwd_cmp.sv
// fwd_cmp -- compares one ID source register against the in-flight writer
// records and returns the youngest-first forwarding select.
//   src            : source register of the ID instruction
//   ex_rd/ex_we    : EX record destination and write enable
//   mem_rd/mem_we  : MEM record destination and write enable
//   wb_rd/wb_we    : WB record (present only with FWD_WB_BYPASS_EN)
//   sel            : FWD_RF when no live writer matches; x0 never forwards
// Build option: FWD_WB_BYPASS_EN adds the WB comparison (select FWD_WBD).
module fwd_cmp
    import plriscv_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
`ifdef FWD_WB_BYPASS_EN
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
`endif
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (ex_we && (ex_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (mem_we && (mem_rd == src)) begin
                sel = FWD_MEMWB;
            end
`ifdef FWD_WB_BYPASS_EN
            else if (wb_we && (wb_rd == src)) begin
                sel = FWD_WBD;
            end
`endif
        end
    end

endmodule

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen -- tracks destination registers of in-flight instructions and
// produces registered EX operand-forwarding selects plus a load-use hazard.
//   clk, rst_n              : clock, async active-low reset
//   id_rs1/id_rs2/id_rd     : registers of the instruction in ID
//   id_valid/id_reg_write/id_is_load : ID instruction qualifiers
//   stall                   : external hold of the pipeline
//   flush                   : IF/ID flush, turns the ID instruction into a bubble
//   ex_sel_a/ex_sel_b       : EX operand mux selects, valid while the instruction is in EX
//   load_use_stall          : combinational hold request for a load-use hazard
// Build option: FWD_WB_BYPASS_EN keeps a third (WB) record and enables select 11;
// without it the register file is assumed write-first and only EX/MEM are tracked.
module fwd_sel_gen
    import plriscv_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic              load_use_stall
);

    // Local record type so rd follows REG_AW rather than the package default.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } rec_t;

    rec_t     ex_q, ex_d, mem_q, mem_d;
`ifdef FWD_WB_BYPASS_EN
    rec_t     wb_q, wb_d;
`endif
    fwd_sel_e sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    fwd_sel_e cmp_sel_a, cmp_sel_b;
    logic     lu_hit;

    fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
        .src    (id_rs1),
        .ex_rd  (ex_q.rd),
        .ex_we  (ex_q.reg_write),
        .mem_rd (mem_q.rd),
        .mem_we (mem_q.reg_write),
`ifdef FWD_WB_BYPASS_EN
        .wb_rd  (wb_q.rd),
        .wb_we  (wb_q.reg_write),
`endif
        .sel    (cmp_sel_a)
    );

    fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
        .src    (id_rs2),
        .ex_rd  (ex_q.rd),
        .ex_we  (ex_q.reg_write),
        .mem_rd (mem_q.rd),
        .mem_we (mem_q.reg_write),
`ifdef FWD_WB_BYPASS_EN
        .wb_rd  (wb_q.rd),
        .wb_we  (wb_q.reg_write),
`endif
        .sel    (cmp_sel_b)
    );

    // A load in EX cannot forward its data yet; the dependent ID instruction waits a cycle.
    assign lu_hit = id_valid && ex_q.is_load && ex_q.reg_write && (ex_q.rd != '0) &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    assign load_use_stall = lu_hit;

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
`ifdef FWD_WB_BYPASS_EN
        wb_d    = wb_q;
`endif
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        // Flush / invalid ID beat stall; stall beats the load-use bubble.
        if (flush || !id_valid || (!stall)) begin
            mem_d = ex_q;
`ifdef FWD_WB_BYPASS_EN
            wb_d  = mem_q;
`endif
            if (flush || !id_valid || lu_hit) begin
                ex_d    = '0;
                sel_a_d = FWD_RF;
                sel_b_d = FWD_RF;
            end else begin
                ex_d    = '{rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
                sel_a_d = cmp_sel_a;
                sel_b_d = cmp_sel_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
`ifdef FWD_WB_BYPASS_EN
            wb_q    <= '0;
`endif
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
`ifdef FWD_WB_BYPASS_EN
            wb_q    <= wb_d;
`endif
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign ex_sel_a = sel_a_q;
    assign ex_sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_sel_gen.sv
// tb_fwd_sel_gen -- directed checks of forwarding selects and load-use detection.
module tb_fwd_sel_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_valid, id_reg_write, id_is_load;
    logic       stall, flush;
    logic [1:0] ex_sel_a, ex_sel_b;
    logic       load_use_stall;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_sel_gen #(.REG_AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_valid       (id_valid),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .stall          (stall),
        .flush          (flush),
        .ex_sel_a       (ex_sel_a),
        .ex_sel_b       (ex_sel_b),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive an instruction into ID (inputs only, no clock).
    task automatic drive(input int rd, input int rs1, input int rs2, input bit we, input bit ld);
        id_rd        = rd[4:0];
        id_rs1       = rs1[4:0];
        id_rs2       = rs2[4:0];
        id_reg_write = we;
        id_is_load   = ld;
        id_valid     = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int rs1, input int rs2, input bit we, input bit ld);
        drive(rd, rs1, rs2, we, ld);
        tick();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) begin
            id_valid = 1'b0;
            id_reg_write = 1'b0;
            id_is_load = 1'b0;
            tick();
        end
    endtask

    task automatic sels(input string tag, input int a, input int b);
        check({tag, "_a"}, ex_sel_a, a);
        check({tag, "_b"}, ex_sel_b, b);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        id_reg_write = 1'b0;
        id_is_load = 1'b0;
        id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        #12;
        sels("reset", 0, 0);
        check("reset_lus", load_use_stall, 0);
        tick();
        rst_n = 1'b1;
        check("post_reset_lus", load_use_stall, 0);

        // add x5; add x6,x5,x1
        issue(5, 1, 2, 1, 0);
        issue(6, 5, 1, 1, 0);
        sels("b2b", 1, 0);

        // add x5; nop; sub x7,x1,x5
        bubbles(3);
        issue(5, 1, 2, 1, 0);
        bubbles(1);
        issue(7, 1, 5, 1, 0);
        sels("gap1", 0, 2);

        // add x5; nop; nop; sub x7,x1,x5
        bubbles(3);
        issue(5, 1, 2, 1, 0);
        bubbles(2);
        issue(7, 1, 5, 1, 0);
`ifdef FWD_WB_BYPASS_EN
        sels("gap2", 0, 3);
`else
        sels("gap2", 0, 0);
`endif

        // record retires after three advances
        bubbles(3);
        issue(5, 1, 2, 1, 0);
        bubbles(3);
        issue(7, 5, 5, 1, 0);
        sels("retired", 0, 0);

        // lw x8; add x9,x8,x8
        bubbles(3);
        issue(8, 1, 0, 1, 1);
        drive(9, 8, 8, 1, 0);
        #1;
        check("lu_hit", load_use_stall, 1);
        tick();
        sels("lu_bubble", 0, 0);
        check("lu_one_cycle", load_use_stall, 0);
        tick();
        sels("lu_after", 2, 2);

        // writes and load to x0, reader of x0
        bubbles(3);
        issue(0, 1, 2, 1, 0);
        issue(0, 1, 2, 1, 1);
        drive(3, 0, 0, 1, 0);
        #1;
        check("x0_lus", load_use_stall, 0);
        tick();
        sels("x0", 0, 0);

        // two writes to x5, youngest wins
        bubbles(3);
        issue(5, 1, 2, 1, 0);
        issue(5, 3, 4, 1, 0);
        issue(9, 5, 5, 1, 0);
        sels("youngest", 1, 1);

        // external stall holds records and selects
        bubbles(3);
        issue(5, 1, 2, 1, 0);
        issue(6, 5, 0, 1, 0);
        sels("pre_stall", 1, 0);
        drive(7, 5, 6, 1, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            sels($sformatf("stall%0d", i), 1, 0);
        end
        stall = 1'b0;
        tick();
        sels("stall_release", 2, 1);

        // flush overrides stall
        drive(8, 7, 7, 1, 0);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        sels("flush_stall", 0, 0);
        flush = 1'b0;
        stall = 1'b0;

        // reset in the middle of a load-use while stalled
        bubbles(3);
        issue(8, 1, 0, 1, 1);
        drive(9, 8, 8, 1, 0);
        #1;
        check("pre_rst_lus", load_use_stall, 1);
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_lus", load_use_stall, 0);
        sels("mid_rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        #1;
        check("after_rst_lus", load_use_stall, 0);
        tick();
        sels("after_rst", 0, 0);
        check("after_rst_lus2", load_use_stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
